// File: rtl/vga_timing_gen_pkg.sv
// Shared mode constants for the VGA raster: 800x600@60 on a 40 MHz pixel clock.
// Pixel-stage logic and future modes import the same values from here.
package vga_timing_gen_pkg;

    localparam int COUNT_W   = 11;
    localparam int COUNT_MAX = 2048;

    localparam int MODE_H_VISIBLE = 800;
    localparam int MODE_H_FRONT   = 40;
    localparam int MODE_H_SYNC    = 128;
    localparam int MODE_H_BACK    = 88;
    localparam int MODE_V_VISIBLE = 600;
    localparam int MODE_V_FRONT   = 1;
    localparam int MODE_V_SYNC    = 4;
    localparam int MODE_V_BACK    = 23;

    typedef logic [COUNT_W-1:0] coord_t;

    function automatic int axis_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_axis.sv
// One raster axis: wrapping counter with registered terminal count and sync window.
// The next-state count is exported so the parent can register events aligned to it.
module vga_axis
    import vga_timing_gen_pkg::*;
#(
    parameter int VISIBLE  = MODE_H_VISIBLE,
    parameter int FRONT    = MODE_H_FRONT,
    parameter int SYNC     = MODE_H_SYNC,
    parameter int BACK     = MODE_H_BACK,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    output logic [COUNT_W-1:0] o_count,
    output logic [COUNT_W-1:0] o_next,
    output logic               o_tc,
    output logic               o_sync,
    output logic               o_visible_next
);

    localparam int TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);
    localparam logic [COUNT_W-1:0] LAST       = COUNT_W'(TOTAL - 1);
    localparam logic [COUNT_W-1:0] SYNC_FIRST = COUNT_W'(VISIBLE + FRONT);
    localparam logic [COUNT_W-1:0] SYNC_LAST  = COUNT_W'(VISIBLE + FRONT + SYNC - 1);
    localparam logic [COUNT_W-1:0] VIS_END    = COUNT_W'(VISIBLE);

    if (TOTAL > COUNT_MAX) begin : g_bad_total
        $error("vga_axis: total of %0d does not fit the 11-bit counter", TOTAL);
    end

    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] w_next;
    logic               r_tc;
    logic               r_sync;

    always_comb begin
        w_next = r_count;
        if (i_en) begin
            if (r_count == LAST) begin
                w_next = '0;
            end else begin
                w_next = r_count + COUNT_W'(1);
            end
        end
    end

    // Reset parks the counter on its last position so the first enabled edge lands on 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= LAST;
            r_tc    <= 1'b1;
            r_sync  <= ~SYNC_POL;
        end else begin
            r_count <= w_next;
            r_tc    <= (w_next == LAST);
            r_sync  <= ((w_next >= SYNC_FIRST) && (w_next <= SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign o_count        = r_count;
    assign o_next         = w_next;
    assign o_tc           = r_tc;
    assign o_sync         = r_sync;
    assign o_visible_next = (w_next < VIS_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator; every output is a flop and all of them
// describe the same raster position in a given cycle.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_VISIBLE  = MODE_H_VISIBLE,
    parameter int H_FRONT    = MODE_H_FRONT,
    parameter int H_SYNC     = MODE_H_SYNC,
    parameter int H_BACK     = MODE_H_BACK,
    parameter int V_VISIBLE  = MODE_V_VISIBLE,
    parameter int V_FRONT    = MODE_V_FRONT,
    parameter int V_SYNC     = MODE_V_SYNC,
    parameter int V_BACK     = MODE_V_BACK,
    parameter bit H_SYNC_POL = 1'b1,
    parameter bit V_SYNC_POL = 1'b1
) (
    input  logic               CLK_PIXEL,
    input  logic               RESET,
    output logic               VGA_HSYNC,
    output logic               VGA_VSYNC,
    output logic [COUNT_W-1:0] PIXEL_X,
    output logic [COUNT_W-1:0] PIXEL_Y,
    output logic               ON_SCREEN,
    output logic               LINE_START,
    output logic               FRAME_START,
    output logic               VBLANK_START
);

    localparam coord_t VBLANK_LINE = COUNT_W'(V_VISIBLE);

    coord_t w_h_next;
    coord_t w_v_next;
    logic   w_h_tc;
    logic   w_v_tc_unused;
    logic   w_h_vis_next;
    logic   w_v_vis_next;

    logic   r_on_screen;
    logic   r_line_start;
    logic   r_frame_start;
    logic   r_vblank_start;

    vga_axis #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .SYNC_POL(H_SYNC_POL)
    ) u_h_axis (
        .i_clk         (CLK_PIXEL),
        .i_rst         (RESET),
        .i_en          (1'b1),
        .o_count       (PIXEL_X),
        .o_next        (w_h_next),
        .o_tc          (w_h_tc),
        .o_sync        (VGA_HSYNC),
        .o_visible_next(w_h_vis_next)
    );

    // The line advances on the same edge that the column wraps to 0.
    vga_axis #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .SYNC_POL(V_SYNC_POL)
    ) u_v_axis (
        .i_clk         (CLK_PIXEL),
        .i_rst         (RESET),
        .i_en          (w_h_tc),
        .o_count       (PIXEL_Y),
        .o_next        (w_v_next),
        .o_tc          (w_v_tc_unused),
        .o_sync        (VGA_VSYNC),
        .o_visible_next(w_v_vis_next)
    );

    always_ff @(posedge CLK_PIXEL or posedge RESET) begin
        if (RESET) begin
            r_on_screen    <= 1'b0;
            r_line_start   <= 1'b0;
            r_frame_start  <= 1'b0;
            r_vblank_start <= 1'b0;
        end else begin
            r_on_screen    <= w_h_vis_next && w_v_vis_next;
            r_line_start   <= (w_h_next == '0);
            r_frame_start  <= (w_h_next == '0) && (w_v_next == '0);
            r_vblank_start <= (w_h_next == '0) && (w_v_next == VBLANK_LINE);
        end
    end

    assign ON_SCREEN    = r_on_screen;
    assign LINE_START   = r_line_start;
    assign FRAME_START  = r_frame_start;
    assign VBLANK_START = r_vblank_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size mode plus two reduced modes (both sync polarities)
// checked every cycle against a raster model derived from the pixel index.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        hs;
    logic        vs;
    logic        on;
    logic        ls;
    logic        fs;
    logic        vb;
  } obs_t;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb;
    bit hp, vp;
  } mode_t;

  localparam int OBS_W = $bits(obs_t);
  localparam int W     = 3 * OBS_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        b_hs, b_vs, b_on, b_ls, b_fs, b_vb;
  logic [10:0] b_x, b_y;
  logic        s_hs, s_vs, s_on, s_ls, s_fs, s_vb;
  logic [10:0] s_x, s_y;
  logic        n_hs, n_vs, n_on, n_ls, n_fs, n_vb;
  logic [10:0] n_x, n_y;

  vga_timing_gen u_big (
    .CLK_PIXEL   (clk),
    .RESET       (rst),
    .VGA_HSYNC   (b_hs),
    .VGA_VSYNC   (b_vs),
    .PIXEL_X     (b_x),
    .PIXEL_Y     (b_y),
    .ON_SCREEN   (b_on),
    .LINE_START  (b_ls),
    .FRAME_START (b_fs),
    .VBLANK_START(b_vb)
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) u_small (
    .CLK_PIXEL   (clk),
    .RESET       (rst),
    .VGA_HSYNC   (s_hs),
    .VGA_VSYNC   (s_vs),
    .PIXEL_X     (s_x),
    .PIXEL_Y     (s_y),
    .ON_SCREEN   (s_on),
    .LINE_START  (s_ls),
    .FRAME_START (s_fs),
    .VBLANK_START(s_vb)
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
  ) u_neg (
    .CLK_PIXEL   (clk),
    .RESET       (rst),
    .VGA_HSYNC   (n_hs),
    .VGA_VSYNC   (n_vs),
    .PIXEL_X     (n_x),
    .PIXEL_Y     (n_y),
    .ON_SCREEN   (n_on),
    .LINE_START  (n_ls),
    .FRAME_START (n_fs),
    .VBLANK_START(n_vb)
  );

  obs_t act_b, act_s, act_n;
  assign act_b = {b_x, b_y, b_hs, b_vs, b_on, b_ls, b_fs, b_vb};
  assign act_s = {s_x, s_y, s_hs, s_vs, s_on, s_ls, s_fs, s_vb};
  assign act_n = {n_x, n_y, n_hs, n_vs, n_on, n_ls, n_fs, n_vb};

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc    = -1;
  int cnt_ls   = 0;
  int cnt_fs   = 0;
  int cnt_vb   = 0;
  mode_t m_big, m_small, m_neg;

  function automatic mode_t mk(input int hv, input int hf, input int hs, input int hb,
                               input int vv, input int vf, input int vs, input int vb,
                               input bit hp, input bit vp);
    mode_t m;
    m.hv = hv; m.hf = hf; m.hs = hs; m.hb = hb;
    m.vv = vv; m.vf = vf; m.vs = vs; m.vb = vb;
    m.hp = hp; m.vp = vp;
    return m;
  endfunction

  // Reference raster: n is the number of edges since reset release (-1 while in reset).
  function automatic obs_t model(input mode_t m, input int n);
    obs_t o;
    int ht, vt, frame, p, x, y;
    ht    = m.hv + m.hf + m.hs + m.hb;
    vt    = m.vv + m.vf + m.vs + m.vb;
    frame = ht * vt;
    p     = (n < 0) ? frame - 1 : n % frame;
    x     = p % ht;
    y     = p / ht;
    o.x   = 11'(x);
    o.y   = 11'(y);
    o.hs  = (x >= m.hv + m.hf && x < m.hv + m.hf + m.hs) ? m.hp : !m.hp;
    o.vs  = (y >= m.vv + m.vf && y < m.vv + m.vf + m.vs) ? m.vp : !m.vp;
    o.on  = (n >= 0) && (x < m.hv) && (y < m.vv);
    o.ls  = (n >= 0) && (x == 0);
    o.fs  = (n >= 0) && (p == 0);
    o.vb  = (n >= 0) && (x == 0) && (y == m.vv);
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got x=%0d y=%0d hs=%b vs=%b on=%b ls=%b fs=%b vb=%b, exp x=%0d y=%0d hs=%b vs=%b on=%b ls=%b fs=%b vb=%b",
               name, act.x, act.y, act.hs, act.vs, act.on, act.ls, act.fs, act.vb,
               exp.x, exp.y, exp.hs, exp.vs, exp.on, exp.ls, exp.fs, exp.vb);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", name, act, exp);
    end
  endtask

  // monitor: one expected entry per sampled cycle, compared mid-cycle
  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_obs("big",   act_b, e[3*OBS_W-1:2*OBS_W]);
      check_obs("small", act_s, e[2*OBS_W-1:OBS_W]);
      check_obs("neg",   act_n, e[OBS_W-1:0]);
      cnt_ls = cnt_ls + {31'b0, s_ls};
      cnt_fs = cnt_fs + {31'b0, s_fs};
      cnt_vb = cnt_vb + {31'b0, s_vb};
    end
  end

  // driver tasks
  task automatic push_exp();
    exp_q.push_back({model(m_big, n_cyc), model(m_small, n_cyc), model(m_neg, n_cyc)});
  endtask

  task automatic cycle(input bit async_rst);
    @(posedge clk);
    if (!rst) n_cyc++;
    #1;
    if (async_rst) begin
      rst   = 1'b1;
      n_cyc = -1;
    end
    push_exp();
  endtask

  task automatic run(input int k);
    repeat (k) cycle(1'b0);
  endtask

  task automatic hold_rst(input int k);
    rst   = 1'b1;
    n_cyc = -1;
    repeat (k) cycle(1'b0);
  endtask

  task automatic release_rst();
    rst    = 1'b0;
    cnt_ls = 0;
    cnt_fs = 0;
    cnt_vb = 0;
  endtask

  initial begin
    m_big   = mk(800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1);
    m_small = mk(16, 2, 4, 3, 10, 1, 2, 3, 1'b1, 1'b1);
    m_neg   = mk(16, 2, 4, 3, 10, 1, 2, 3, 1'b0, 1'b0);

    // reset held for 5 cycles, then two full lines plus a bit
    hold_rst(5);
    release_rst();
    run(2 * 1056 + 60);

    // asynchronous reset when the big raster sits at (400,2)
    while (n_cyc < 2 * 1056 + 399) cycle(1'b0);
    cycle(1'b1);
    hold_rst(3);
    release_rst();

    // exactly three reduced-mode frames from a fresh start
    run(3 * 400);
    @(negedge clk);
    #1;
    check_int("frame_starts", cnt_fs, 3);
    check_int("vblank_starts", cnt_vb, 3);
    check_int("line_starts", cnt_ls, 3 * 16);

    // random run lengths with asynchronous resets at random positions
    for (int i = 0; i < 6; i++) begin
      run($urandom_range(50, 2500));
      cycle(1'b1);
      hold_rst($urandom_range(1, 3));
      release_rst();
    end
    run(100);

    // drain with a bounded wait
    for (int i = 0; i < 4; i++) begin
      if (exp_q.size() > 0) @(negedge clk);
    end
    #1;
    check_int("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
